// File: rtl/booth_iter_mult_ctrl_if.sv
// Handshake and data bundle for the iterative radix-4 Booth multiplier:
// operand side (in_valid/in_ready/x/y/abort) and product side (out_valid/out_ready/product).
interface booth_iter_mult_ctrl_if #(parameter int WIDTH = 32);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   x;
  logic signed [WIDTH-1:0]   y;
  logic                      abort;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [2*WIDTH-1:0] product;

  modport master (
    output in_valid, x, y, abort, out_ready,
    input  in_ready, busy, out_valid, product
  );

  modport slave (
    input  in_valid, x, y, abort, out_ready,
    output in_ready, busy, out_valid, product
  );
endinterface

// File: rtl/booth_iter_mult_ctrl.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle from a 3-bit
// window of the multiplier, accumulated into a 2*WIDTH register over WIDTH/2 cycles.
module booth_iter_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_iter_mult_ctrl_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                state;
  logic [CW-1:0]             cnt;
  logic signed [WIDTH-1:0]   xr;
  logic [WIDTH:0]            yr;
  logic signed [2*WIDTH-1:0] acc;
  logic signed [2*WIDTH-1:0] acc_next;
  logic signed [2*WIDTH-1:0] pp_ext;
  logic signed [2*WIDTH-1:0] addend;
  logic signed [2*WIDTH-1:0] product_r;
  logic [WIDTH:0]            ysh;
  logic signed [WIDTH+1:0]   pp;

  // Two extra bits hold +/-2x, including -2 * (-2^(WIDTH-1)) = +2^WIDTH.
  function automatic logic signed [WIDTH+1:0] booth_pp(
    input logic [2:0]              w,
    input logic signed [WIDTH-1:0] xv
  );
    logic signed [WIDTH+1:0] xe;
    logic signed [WIDTH+1:0] r;
    xe = {{2{xv[WIDTH-1]}}, xv};
    case (w)
      3'b001, 3'b010: r = xe;
      3'b011:         r = xe <<< 1;
      3'b100:         r = -(xe <<< 1);
      3'b101, 3'b110: r = -xe;
      default:        r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    ysh      = yr >> {cnt, 1'b0};
    pp       = booth_pp(ysh[2:0], xr);
    pp_ext   = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
    addend   = pp_ext <<< {cnt, 1'b0};
    acc_next = acc + addend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      xr        <= '0;
      yr        <= '0;
      acc       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr    <= bus.x;
            yr    <= {bus.y, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            if (cnt == CW'(N - 1)) begin
              product_r <= acc_next;
              state     <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == CALC);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = product_r;
endmodule

// File: doc/booth_iter_mult_ctrl.md
Name: booth_iter_mult_ctrl

Overview:
- Sequential radix-4 Booth multiplier controller for signed WIDTH x WIDTH operands.
- Instead of building all WIDTH/2 partial products in parallel, it generates one Booth partial product per cycle from a 3-bit window of y.
- Each partial product is accumulated into a 2*WIDTH register.
- It serves as the area-reduced alternative to the parallel partial-product/Wallace path, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- Derived constant N = WIDTH/2, the number of Booth groups (iterations).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand pair present.
- in_ready, output, 1, controller can accept operands.
- x, input, WIDTH, signed multiplicand.
- y, input, WIDTH, signed multiplier.
- abort, input, 1, cancels an operation in progress.
- busy, output, 1, high while in CALC.
- out_valid, output, 1, product available.
- out_ready, input, 1, consumer accepts product.
- product, output, 2*WIDTH, signed x*y.

Behaviour:
- States and outputs:
  - States: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - busy = (state==CALC).
  - out_valid = (state==DONE).
  - All three are registered-state decodes with no combinational path from inputs.
- Reset: rst sampled high at a rising edge forces:
  - state=IDLE, cnt=0, acc=0, product=0.
  - Held x/y registers are set to 0.
  - After reset: in_ready=1, busy=0, out_valid=0.
  - rst has priority over every other input, including mid-CALC and in DONE.
- IDLE:
  - On an edge with in_valid=1, latch x into xr and {y,1'b0} into yr (WIDTH+1 bits, implicit y[-1]=0).
  - At the same edge: acc<=0, cnt<=0, go to CALC.
  - in_valid=0 leaves the state unchanged.
- CALC, one group per cycle; group i=cnt uses window w = yr[2i+2:2i] (= y[2i+1], y[2i], y[2i-1]):
  - w=000 or 111: pp=0.
  - w=001 or 010: pp=+xr.
  - w=011: pp=+2xr.
  - w=100: pp=-2xr.
  - w=101 or 110: pp=-xr.
  - pp is formed at WIDTH+2 bits signed, sign-extended to 2*WIDTH, and shifted left by 2i.
  - acc <= acc + that value, mod 2^(2*WIDTH).
  - cnt increments each cycle. At the edge processing cnt==N-1, product<=final acc value and state goes to DONE.
  - Fixed latency: out_valid first observed high N cycles after the accepting edge (16 for WIDTH=32), independent of operand values.
  - x/y input changes during CALC have no effect.
- abort:
  - Sampled only in CALC. abort=1 returns the controller to IDLE at that edge.
  - acc is discarded, product keeps its old value, and out_valid is never raised for the aborted operation.
  - abort in IDLE or DONE is ignored.
- DONE:
  - product is stable and out_valid=1 until an edge with out_ready=1, then go to IDLE.
  - in_valid is not accepted in DONE, so there is no back-to-back overlap. Minimum spacing between accepts is N+2 cycles when out_ready is held high.
- product holds its last value in IDLE and CALC. It changes only on the CALC->DONE transition or on reset.
- Result: product equals the exact signed two's-complement product x*y for every input pair, including x=y=-2^(WIDTH-1).
- Counter: cnt is ceil(log2(N)) bits wide and never wraps in normal operation.

Test Plan:
- Reset then single op: rst for 2 cycles; in_valid with x=7, y=-3, out_ready=1 -> in_ready drops next cycle, busy=1 for 16 cycles, out_valid=1 on the 16th cycle after accept with product=64'hFFFF_FFFF_FFFF_FFEB (-21); in_ready=1 the following cycle.
- Corner operands:
  - x=y=32'h8000_0000 -> product=64'h4000_0000_0000_0000.
  - x=32'h7FFF_FFFF, y=32'h8000_0000 -> product=64'hC000_0000_8000_0000.
  - x=0, y=-1 -> 0.
- Output backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and product stay stable, in_ready stays 0, and a new in_valid is ignored; product clears to IDLE only on the out_ready=1 edge.
- Abort: assert abort at cnt=5 -> next cycle state=IDLE, in_ready=1, out_valid never rises, product retains the previous result; a following op (x=-5, y=9) returns -45 after 16 cycles.
- Reset mid-operation: rst at cnt=8 -> next cycle in_ready=1, busy=0, out_valid=0, product=0.
- Randomized: 10k random signed pairs with random out_ready stalls, scoreboarded against a 64-bit signed reference model -> zero mismatches, latency always exactly 16.
